hand_datapath: RTL and testbench
================================

Name: hand_datapath

Overview:
- Parametrised successor to the fixed two-hand, three-card baccarat datapath.
- Holds NUM_HANDS hands of up to MAX_CARDS cards each and deals cards through a valid/ready handshake. Each card is appended to the next free slot of the addressed hand, replacing per-slot load strobes.
- Contains its own card source: a free-running 1..13 counter, or an external card for deterministic play and test.
- Produces registered per-hand baccarat scores, card counts and natural flags for the controller FSM.

Parameters:
- NUM_HANDS, 2, number of hands (index 0 = player, 1 = dealer by convention); range 1..8.
- MAX_CARDS, 3, card slots per hand; range 2..8.
- HW, derived max(1, $clog2(NUM_HANDS)), hand-index width.
- CW, derived $clog2(MAX_CARDS+1), card-count width.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear_all  in  1  synchronous new-round clear of all hands.
- deal_valid  in  1  deal request.
- deal_hand  in  HW  target hand of the request.
- deal_ready  out  1  a request is accepted this cycle when deal_valid is also high.
- deal_err  out  1  one-cycle pulse for a rejected request.
- use_ext  in  1  1 = dealt card comes from ext_card; 0 = internal counter.
- ext_card  in  4  external card value, 1..13.
- last_card  out  4  value of the most recently accepted card.
- cards_out  out  NUM_HANDS*MAX_CARDS*4  all card slots, packed. Hand h, slot s occupies bits [(h*MAX_CARDS+s)*4 +: 4]. Empty slot reads 0.
- count_out  out  NUM_HANDS*CW  cards held per hand, packed [h*CW +: CW].
- score_out  out  NUM_HANDS*4  per-hand score 0..9, packed [h*4 +: 4].
- natural_out  out  NUM_HANDS  hand holds exactly 2 cards and scores 8 or 9.

Behaviour:
- Reset: every card slot, count, score, natural flag, last_card and deal_err goes to 0; the internal counter goes to 1. Reset takes effect immediately, including in the middle of a deal; no partial state survives.
- Internal counter: increments every clock, 13 wraps to 1. It never holds 0 or 14..15.
- Card selection: card = use_ext ? ext_card : counter. An ext_card value of 0 or 14..15 is rejected (see deal_err); the stored value is always in 1..13.
- deal_ready is combinational and equals all of:
  - !clear_all;
  - deal_hand < NUM_HANDS;
  - count[deal_hand] < MAX_CARDS;
  - when use_ext = 1, ext_card is in 1..13.
- Accept (deal_valid & deal_ready) on edge t:
  - card is written to slot count[deal_hand];
  - count[deal_hand] increments;
  - last_card is updated.
  - All three are visible after edge t. At most one card is accepted per cycle.
- Reject (deal_valid & !deal_ready): no state changes; deal_err = 1 for exactly the following cycle.
- clear_all: on the edge, all slots and counts go to 0. It has priority over a simultaneous deal (ready is low, so that deal gets deal_err). The counter is not affected. last_card is kept.
- Scoring: card value = card if card <= 9, else 0 (10, J, Q, K count 0). Hand sum is taken mod 10.
- score_out and natural_out are registered from card state, so they lag card/count changes by one cycle.
  - Latency from accept to updated score: 2 edges.
  - After clear_all, score = 0 and natural = 0 one edge later.
- Width rule: the slot sum is at most MAX_CARDS*9 = 72 and fits in 7 bits. Reduce with mod 10; no overflow is possible.
- A full hand stays full until clear_all or reset.

Decomposition:
- hand_pkg holds: card_t (logic [3:0]); constants CARD_MIN = 1, CARD_MAX = 13, FACE_ZERO_FROM = 10; function card_value(card_t) returning 0..9.
- One sub-module, hand_score, is natural: combinational. Inputs are MAX_CARDS cards; outputs are the mod-10 score and the natural flag.
- hand_datapath instantiates NUM_HANDS copies of hand_score via generate and registers their outputs.

Test Plan:
- Reset asserted mid-deal (deal_valid = 1, hand 0), async between edges -> all outputs 0 immediately, counter = 1, deal_ready = 1 after release.
- use_ext = 1; deal 7, 9 to hand 0 and 4, 13 to hand 1 -> score_out hand0 = 6, hand1 = 4; counts 2, 2; natural 0, 0; each score correct 2 edges after its accept.
- Deal 8, 10 to hand 0 -> score 8, natural = 1. Then a third card 1 -> score 9, natural = 0.
- Fill hand 0 with 3 cards, then deal a 4th -> deal_ready = 0, deal_err pulses 1 cycle, cards and count unchanged.
- clear_all with deal_valid asserted in the same cycle -> all counts 0, deal_err = 1, score 0 one edge later, last_card retained. Invalid ext_card = 0 -> rejected with deal_err. deal_hand = 3 with NUM_HANDS = 2 -> rejected with deal_err.
- use_ext = 0; deal on 15 consecutive cycles alternating hands (NUM_HANDS = 2, MAX_CARDS = 8) -> accepted values follow 1..13 wrapping to 1, never 0.

Source files
------------

// File: rtl/hand_pkg.sv
// Shared card types, card constants and the baccarat point-value helper.
// Latency: none (types, constants and combinational functions only).
// Backpressure: not applicable.
package hand_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_MIN       = 4'd1;
    localparam card_t CARD_MAX       = 4'd13;
    localparam card_t FACE_ZERO_FROM = 4'd10;

    // Baccarat point value: 10, J, Q and K are worth nothing.
    function automatic card_t card_value(input card_t card);
        return (card >= FACE_ZERO_FROM) ? 4'd0 : card;
    endfunction

    // A storable card is one of the thirteen ranks; 0 marks an empty slot.
    function automatic logic card_legal(input card_t card);
        return (card >= CARD_MIN) && (card <= CARD_MAX);
    endfunction

endpackage

// File: rtl/hand_score.sv
// Scores one hand: sum of point values mod 10, plus the two-card natural flag.
// Latency: purely combinational.
// Backpressure: none; the result is recomputed every cycle from the slot contents.
module hand_score
    import hand_pkg::*;
#(
    parameter int MAX_CARDS = 3
) (
    input  logic [MAX_CARDS*4-1:0] cards,
    output logic [3:0]             score,
    output logic                   natural
);

    // At most 8 slots of 9 points each, so 7 bits never overflow.
    logic [6:0] sum;
    // Slots fill in order and never hold 0, so non-empty slots equal the card count.
    logic [3:0] held;

    // Accumulate point values and count occupied slots, then reduce mod 10.
    always_comb begin
        sum  = '0;
        held = '0;
        for (int s = 0; s < MAX_CARDS; s++) begin
            sum = sum + 7'(card_value(cards[s*4 +: 4]));
            if (cards[s*4 +: 4] != 4'd0) begin
                held = held + 4'd1;
            end
        end
        score   = 4'(sum % 7'd10);
        natural = (held == 4'd2) && (score >= 4'd8);
    end

endmodule

// File: rtl/hand_datapath.sv
// Holds NUM_HANDS baccarat hands, appends dealt cards and publishes registered scores.
// Latency: card/count/last_card visible 1 edge after accept; score/natural 2 edges.
// Backpressure: deal_ready drops on clear, bad hand index, full hand or illegal ext card; rejects pulse deal_err.
module hand_datapath
    import hand_pkg::*;
#(
    parameter  int NUM_HANDS = 2,
    parameter  int MAX_CARDS = 3,
    localparam int HW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CW        = $clog2(MAX_CARDS + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            clear_all,
    input  logic                            deal_valid,
    input  logic [HW-1:0]                   deal_hand,
    output logic                            deal_ready,
    output logic                            deal_err,
    input  logic                            use_ext,
    input  logic [3:0]                      ext_card,
    output logic [3:0]                      last_card,
    output logic [NUM_HANDS*MAX_CARDS*4-1:0] cards_out,
    output logic [NUM_HANDS*CW-1:0]         count_out,
    output logic [NUM_HANDS*4-1:0]          score_out,
    output logic [NUM_HANDS-1:0]            natural_out
);

    card_t          slot_q  [NUM_HANDS][MAX_CARDS];
    card_t          slot_d  [NUM_HANDS][MAX_CARDS];
    logic [CW-1:0]  count_q [NUM_HANDS];
    logic [CW-1:0]  count_d [NUM_HANDS];
    logic [3:0]     score_q [NUM_HANDS];
    logic [3:0]     score_d [NUM_HANDS];
    logic [NUM_HANDS-1:0] natural_q;
    logic [NUM_HANDS-1:0] natural_d;
    card_t          ctr_q, ctr_d;
    card_t          last_q, last_d;
    logic           err_q, err_d;

    card_t          sel_card;
    logic           hand_ok;
    logic [CW-1:0]  tgt_count;
    logic           room_ok;
    logic           card_ok;
    logic           accept;

    // Handshake: decode the target hand without ever indexing past NUM_HANDS.
    always_comb begin
        sel_card  = use_ext ? ext_card : ctr_q;
        hand_ok   = 1'b0;
        tgt_count = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (HW'(h) == deal_hand) begin
                hand_ok   = 1'b1;
                tgt_count = count_q[h];
            end
        end
        room_ok    = tgt_count < CW'(MAX_CARDS);
        card_ok    = !use_ext || card_legal(ext_card);
        deal_ready = !clear_all && hand_ok && room_ok && card_ok;
        accept     = deal_valid && deal_ready;
    end

    // Next state: clear wins over a deal; an accepted card lands in the next free slot.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        last_d  = last_q;
        ctr_d   = (ctr_q >= CARD_MAX) ? CARD_MIN : ctr_q + 4'd1;
        err_d   = deal_valid && !deal_ready;
        if (clear_all) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                count_d[h] = '0;
                for (int s = 0; s < MAX_CARDS; s++) begin
                    slot_d[h][s] = '0;
                end
            end
        end else if (accept) begin
            last_d = sel_card;
            for (int h = 0; h < NUM_HANDS; h++) begin
                if (HW'(h) == deal_hand) begin
                    count_d[h] = count_q[h] + CW'(1);
                    for (int s = 0; s < MAX_CARDS; s++) begin
                        if (CW'(s) == count_q[h]) begin
                            slot_d[h][s] = sel_card;
                        end
                    end
                end
            end
        end
    end

    // Per-hand scorers run off the registered slots, hence the extra edge of score latency.
    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
        hand_score #(
            .MAX_CARDS (MAX_CARDS)
        ) u_score (
            .cards   (cards_out[h*MAX_CARDS*4 +: MAX_CARDS*4]),
            .score   (score_d[h]),
            .natural (natural_d[h])
        );
    end

    // State registers; reset is asynchronous so a deal in flight leaves nothing behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_q    <= '{default: '0};
            count_q   <= '{default: '0};
            score_q   <= '{default: '0};
            natural_q <= '0;
            ctr_q     <= CARD_MIN;
            last_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            count_q   <= count_d;
            score_q   <= score_d;
            natural_q <= natural_d;
            ctr_q     <= ctr_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    // Flatten the per-hand state onto the packed output buses.
    always_comb begin
        cards_out = '0;
        count_out = '0;
        score_out = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            count_out[h*CW +: CW] = count_q[h];
            score_out[h*4 +: 4]   = score_q[h];
            for (int s = 0; s < MAX_CARDS; s++) begin
                cards_out[(h*MAX_CARDS+s)*4 +: 4] = slot_q[h][s];
            end
        end
        natural_out = natural_q;
        last_card   = last_q;
        deal_err    = err_q;
    end

endmodule

// File: tb/tb_hand_datapath.sv
// Directed plus randomized bench for hand_datapath against a per-hand card-list model.
// Latency: model expects cards after 1 edge and scores after 2 edges.
// Backpressure: model predicts deal_ready and the deal_err pulse each cycle.
module tb_hand_datapath;

    // Three hands so that hand index 3 is an out-of-range request; five slots
    // so fifteen consecutive deals spread over three hands fit exactly.
    localparam int NH = 3;
    localparam int MC = 5;
    localparam int HW = 2;
    localparam int CW = 3;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  clear_all;
    logic                  deal_valid;
    logic [HW-1:0]         deal_hand;
    logic                  deal_ready;
    logic                  deal_err;
    logic                  use_ext;
    logic [3:0]            ext_card;
    logic [3:0]            last_card;
    logic [NH*MC*4-1:0]    cards_out;
    logic [NH*CW-1:0]      count_out;
    logic [NH*4-1:0]       score_out;
    logic [NH-1:0]         natural_out;

    hand_datapath #(
        .NUM_HANDS (NH),
        .MAX_CARDS (MC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clear_all   (clear_all),
        .deal_valid  (deal_valid),
        .deal_hand   (deal_hand),
        .deal_ready  (deal_ready),
        .deal_err    (deal_err),
        .use_ext     (use_ext),
        .ext_card    (ext_card),
        .last_card   (last_card),
        .cards_out   (cards_out),
        .count_out   (count_out),
        .score_out   (score_out),
        .natural_out (natural_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: each hand is a list of cards plus its length.
    int m_cnt   [NH];
    int m_card  [NH][MC];
    int m_score [NH];
    int m_nat   [NH];
    int m_last;
    int m_ctr;
    int m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hand_points(input int h);
        int sum = 0;
        for (int i = 0; i < m_cnt[h]; i++) begin
            sum += (m_card[h][i] <= 9) ? m_card[h][i] : 0;
        end
        return sum % 10;
    endfunction

    function automatic bit model_ready();
        if (clear_all) return 1'b0;
        if (int'(deal_hand) >= NH) return 1'b0;
        if (m_cnt[deal_hand] >= MC) return 1'b0;
        if (use_ext && (ext_card < 1 || ext_card > 13)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_cnt[h]   = 0;
            m_score[h] = 0;
            m_nat[h]   = 0;
        end
        m_last = 0;
        m_ctr  = 1;
        m_err  = 0;
    endtask

    task automatic check_outputs();
        logic [63:0] exp_cards = '0;
        logic [63:0] exp_cnt   = '0;
        logic [63:0] exp_score = '0;
        logic [63:0] exp_nat   = '0;
        for (int h = 0; h < NH; h++) begin
            exp_cnt[h*CW +: CW]  = CW'(m_cnt[h]);
            exp_score[h*4 +: 4]  = 4'(m_score[h]);
            exp_nat[h]           = (m_nat[h] != 0);
            for (int s = 0; s < MC; s++) begin
                exp_cards[(h*MC+s)*4 +: 4] = (s < m_cnt[h]) ? 4'(m_card[h][s]) : 4'd0;
            end
        end
        check("cards_out",   64'(cards_out),   exp_cards);
        check("count_out",   64'(count_out),   exp_cnt);
        check("score_out",   64'(score_out),   exp_score);
        check("natural_out", 64'(natural_out), exp_nat);
        check("last_card",   64'(last_card),   64'(m_last));
        check("deal_err",    64'(deal_err),    64'(m_err));
    endtask

    // One clock: predict ready, step the model across the edge, then compare.
    task automatic tick();
        bit rdy;
        bit acc;
        int card;
        int hand;
        int ns [NH];
        int nn [NH];
        #1;
        rdy  = model_ready();
        check("deal_ready", 64'(deal_ready), 64'(rdy));
        card = use_ext ? int'(ext_card) : m_ctr;
        hand = int'(deal_hand);
        acc  = deal_valid && rdy;
        for (int h = 0; h < NH; h++) begin
            ns[h] = hand_points(h);
            nn[h] = (m_cnt[h] == 2 && ns[h] >= 8) ? 1 : 0;
        end
        @(posedge clock);
        m_err = (deal_valid && !rdy) ? 1 : 0;
        if (clear_all) begin
            for (int h = 0; h < NH; h++) m_cnt[h] = 0;
        end else if (acc) begin
            m_card[hand][m_cnt[hand]] = card;
            m_cnt[hand]++;
            m_last = card;
        end
        m_ctr = (m_ctr == 13) ? 1 : m_ctr + 1;
        for (int h = 0; h < NH; h++) begin
            m_score[h] = ns[h];
            m_nat[h]   = nn[h];
        end
        #1;
        check_outputs();
    endtask

    task automatic deal(input bit v, input int hand, input bit ue, input int ext, input bit clr);
        deal_valid = v;
        deal_hand  = HW'(hand);
        use_ext    = ue;
        ext_card   = 4'(ext);
        clear_all  = clr;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        clear_all  = 1'b0;
        deal_valid = 1'b0;
        deal_hand  = '0;
        use_ext    = 1'b0;
        ext_card   = 4'd0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_outputs();
        check("deal_ready_in_reset", 64'(deal_ready), 64'(model_ready()));
        reset = 1'b0;

        // External cards: hand0 = 7,9 -> 6; hand1 = 4,K -> 4.
        deal(1, 0, 1, 7, 0);
        deal(1, 0, 1, 9, 0);
        deal(1, 1, 1, 4, 0);
        deal(1, 1, 1, 13, 0);
        deal(0, 0, 0, 0, 0);
        check("score_h0_7_9", 64'(score_out[3:0]), 64'd6);
        check("score_h1_4_K", 64'(score_out[7:4]), 64'd4);
        check("count_h1_two", 64'(count_out[2*CW-1:CW]), 64'd2);
        check("natural_none", 64'(natural_out), 64'd0);

        // Natural 8 from 8,10, then a third card breaks the natural.
        deal(0, 0, 0, 0, 1);
        deal(1, 0, 1, 8, 0);
        deal(1, 0, 1, 10, 0);
        deal(0, 0, 0, 0, 0);
        check("natural_h0_8_10", 64'(natural_out[0]), 64'd1);
        check("score_h0_8_10",   64'(score_out[3:0]), 64'd8);
        deal(1, 0, 1, 1, 0);
        deal(0, 0, 0, 0, 0);
        check("score_h0_third", 64'(score_out[3:0]), 64'd9);
        check("natural_h0_gone", 64'(natural_out[0]), 64'd0);

        // Fill hand 0, then one more is refused for exactly one cycle.
        deal(1, 0, 1, 2, 0);
        deal(1, 0, 1, 3, 0);
        deal(1, 0, 1, 5, 0);
        check("err_full_hand", 64'(deal_err), 64'd1);
        check("count_h0_full", 64'(count_out[CW-1:0]), 64'(MC));
        deal(0, 0, 0, 0, 0);
        check("err_one_cycle", 64'(deal_err), 64'd0);

        // Clear racing a deal; illegal ext card; out-of-range hand.
        deal(1, 1, 1, 6, 1);
        check("err_on_clear", 64'(deal_err), 64'd1);
        check("count_cleared", 64'(count_out), 64'd0);
        check("last_kept", 64'(last_card), 64'd3);
        deal(0, 0, 0, 0, 0);
        check("score_cleared", 64'(score_out), 64'd0);
        deal(1, 0, 1, 0, 0);
        check("err_ext_zero", 64'(deal_err), 64'd1);
        deal(1, 3, 1, 5, 0);
        check("err_bad_hand", 64'(deal_err), 64'd1);

        // Asynchronous reset landing between edges while a deal is requested.
        deal(1, 0, 1, 9, 0);
        deal_valid = 1'b1;
        deal_hand  = '0;
        use_ext    = 1'b1;
        ext_card   = 4'd5;
        clear_all  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("ready_mid_reset", 64'(deal_ready), 64'd1);
        #1;
        reset = 1'b0;
        deal(1, 0, 0, 0, 0);
        check("ctr_restart_1", 64'(last_card), 64'd1);

        // Internal counter over fifteen back-to-back deals: 1..13 then wraps.
        deal(0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            deal(1, i % 3, 0, 0, 0);
            check("ctr_nonzero", 64'(last_card != 4'd0), 64'd1);
        end

        // Randomized mix of deals, rejects and clears.
        for (int i = 0; i < 400; i++) begin
            deal($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                 $urandom_range(0, 15), $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
